cordic_atan2_mag: RTL



---
 rtl/cordic_atan2_mag.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cordic_atan2_mag.sv
`default_nettype none
// ============================================================================
// Module   : cordic_atan2_mag
// Purpose  : 16-stage iterative vectoring CORDIC that returns atan2(y, x) and
//            the gain-compensated magnitude. CORDIC_ATAN_DEG_EN selects
//            integer-degree angle output instead of Q3.13 radians.
// Revision : 1.0  initial release
// ============================================================================
module cordic_atan2_mag #(
    parameter int ITER = 16,
    parameter int ZW   = 18,
    parameter int XW   = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic signed [15:0] angle_out,
    output logic        [15:0] mag_out,
    output logic               busy,
    output logic               done
);

    localparam int                  c_KW       = $clog2(ITER);
    localparam logic signed [ZW-1:0] c_PI      = ZW'(51472);
    localparam logic [XW+15:0]      c_INV_GAIN = (XW+16)'(39797);
    localparam logic [XW+15:0]      c_MAG_RND  = (XW+16)'(32768);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_SCALE = 2'd2
    } state_t;

    state_t                r_state;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic signed [ZW-1:0]  r_z;
    logic [c_KW-1:0]       r_k;
    logic                  r_zero;

    // round(atan(2^-k) * 2^14); the last entry rounds down to zero
    function automatic logic signed [ZW-1:0] atan_rom(input logic [c_KW-1:0] idx);
        case (int'(idx))
            0:       atan_rom = ZW'(12868);
            1:       atan_rom = ZW'(7596);
            2:       atan_rom = ZW'(4014);
            3:       atan_rom = ZW'(2037);
            4:       atan_rom = ZW'(1023);
            5:       atan_rom = ZW'(512);
            6:       atan_rom = ZW'(256);
            7:       atan_rom = ZW'(128);
            8:       atan_rom = ZW'(64);
            9:       atan_rom = ZW'(32);
            10:      atan_rom = ZW'(16);
            11:      atan_rom = ZW'(8);
            12:      atan_rom = ZW'(4);
            13:      atan_rom = ZW'(2);
            14:      atan_rom = ZW'(1);
            default: atan_rom = '0;
        endcase
    endfunction

    logic signed [XW-1:0] w_x_ext;
    logic signed [XW-1:0] w_y_ext;
    logic signed [XW-1:0] w_x_sh;
    logic signed [XW-1:0] w_y_sh;
    logic signed [ZW-1:0] w_atan;
    logic                 w_y_pos;
    logic [XW-1:0]        w_x_pos;
    logic [XW+15:0]       w_mag_prod;
    logic [XW-1:0]        w_mag_hi;
    logic [15:0]          w_mag_sat;
    logic signed [15:0]   w_angle;

    assign w_x_ext = XW'(x_in);
    assign w_y_ext = XW'(y_in);
    assign w_x_sh  = r_x >>> r_k;
    assign w_y_sh  = r_y >>> r_k;
    assign w_atan  = atan_rom(r_k);
    assign w_y_pos = ~r_y[XW-1];

    // x stays non-negative in vectoring mode; clamp defensively before scaling
    assign w_x_pos    = r_x[XW-1] ? '0 : r_x;
    assign w_mag_prod = (XW+16)'(w_x_pos) * c_INV_GAIN + c_MAG_RND;
    assign w_mag_hi   = XW'(w_mag_prod >> 16);
    assign w_mag_sat  = (|w_mag_hi[XW-1:16]) ? 16'hFFFF : w_mag_hi[15:0];

`ifdef CORDIC_ATAN_DEG_EN
    localparam logic signed [ZW+12:0] c_DEG_K   = (ZW+13)'(3667);
    localparam logic signed [ZW+12:0] c_DEG_RND = (ZW+13)'(524288);

    logic signed [ZW+12:0] w_deg_prod;

    assign w_deg_prod = (ZW+13)'(r_z) * c_DEG_K + c_DEG_RND;
    assign w_angle    = 16'(w_deg_prod >>> 20);
`else
    logic signed [ZW:0] w_z_rnd;

    assign w_z_rnd = (ZW+1)'(r_z) + (ZW+1)'(1);
    assign w_angle = 16'(w_z_rnd >>> 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_k       <= '0;
            r_zero    <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // left half-plane inputs are folded into the right half by a pi rotation
                        r_x     <= x_in[15] ? -w_x_ext : w_x_ext;
                        r_y     <= x_in[15] ? -w_y_ext : w_y_ext;
                        r_z     <= x_in[15] ? (y_in[15] ? -c_PI : c_PI) : '0;
                        r_k     <= '0;
                        r_zero  <= (x_in == 16'sd0) && (y_in == 16'sd0);
                        busy    <= 1'b1;
                        r_state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (w_y_pos) begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - w_atan;
                    end
                    r_k <= r_k + c_KW'(1);
                    if (r_k == c_KW'(ITER - 1)) begin
                        r_state <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    angle_out <= r_zero ? 16'sd0 : w_angle;
                    mag_out   <= r_zero ? 16'd0  : w_mag_sat;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
